pair_triple_event_counter: RTL and testbench



---
 rtl/pair_triple_event_counter.sv | 139 +++++++++++++
 tb/tb_pair_triple_event_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pair_triple_event_counter.sv
// pair_triple_event_counter: qualifies the 2-of-3 detector output against a
// minimum persistence of HOLD consecutive high samples, emits one single-cycle
// event per qualified high run and keeps a saturating, sticky-flagged count.
//
// Parameters:
//   CNT_W  event counter width (2..16)
//   HOLD   consecutive high det samples needed to qualify (1..15)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     enable; low forces the FSM to IDLE and blocks counting
//   det    detector output
//   clear  synchronous clear of cnt and sat (wins over an increment)
//   evt    one-cycle pulse per qualified run ("event" is a reserved word)
//   cnt    saturating event count
//   sat    sticky, set when cnt reaches its maximum
//   state  current FSM state: IDLE=0, ARM=1, FIRE=2, WAIT_LOW=3
// Build option:
//   PAIR_TRIPLE_EVENT_COUNTER_SYNC_EN  when defined, det passes through a
//   2-flop synchronizer (reset to 0) before the FSM, adding 2 cycles latency.

module pair_triple_event_counter #(
    parameter int CNT_W = 8,
    parameter int HOLD  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             det,
    input  logic             clear,
    output logic             evt,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        FIRE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    localparam logic [3:0]       HOLD_V  = 4'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           cur;
    state_t           nxt;
    logic [3:0]       run;
    logic [3:0]       run_nxt;
    logic [3:0]       run_inc;
    logic             det_q;
    logic             inc;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef PAIR_TRIPLE_EVENT_COUNTER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], det};
        end
    end

    assign det_q = sync_q[1];
`else
    assign det_q = det;
`endif

    assign run_inc = run + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= IDLE;
            run <= 4'd0;
        end else begin
            cur <= nxt;
            run <= run_nxt;
        end
    end

    // Next-state logic. Ternaries on det_q let an unknown det reach the
    // state register instead of being silently treated as low.
    always_comb begin
        nxt     = cur;
        run_nxt = run;
        if (!en) begin
            nxt     = IDLE;
            run_nxt = 4'd0;
        end else begin
            unique case (cur)
                IDLE: begin
                    nxt     = det_q ? ((HOLD == 1) ? FIRE : ARM) : IDLE;
                    run_nxt = (det_q && HOLD != 1) ? 4'd1 : 4'd0;
                end
                ARM: begin
                    nxt     = det_q ? ((run_inc == HOLD_V) ? FIRE : ARM)
                                    : IDLE;
                    run_nxt = (det_q && run_inc != HOLD_V) ? run_inc : 4'd0;
                end
                FIRE: begin
                    nxt     = det_q ? WAIT_LOW : IDLE;
                    run_nxt = 4'd0;
                end
                WAIT_LOW: begin
                    nxt     = det_q ? WAIT_LOW : IDLE;
                    run_nxt = 4'd0;
                end
            endcase
        end
    end

    // Moore outputs
    always_comb begin
        evt   = (cur == FIRE);
        state = cur;
    end

    // Count on the edge that enters FIRE; clear takes priority.
    assign inc     = (nxt == FIRE);
    assign cnt_nxt = clear ? '0
                   : (inc && cnt != CNT_MAX) ? cnt + CNT_ONE
                   : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= clear ? 1'b0 : (sat | (cnt_nxt == CNT_MAX));
        end
    end

endmodule

// File: tb/tb_pair_triple_event_counter.sv
// tb_pair_triple_event_counter
// Directed checks, HOLD=3 and HOLD=1 DUTs.

module tb_pair_triple_event_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b1;
  logic       det_a = 1'b0;
  logic       clr_a = 1'b0;
  logic       en_b = 1'b1;
  logic       det_b = 1'b0;
  logic       clr_b = 1'b0;
  logic       evt_a, sat_a;
  logic       evt_b, sat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b, st_a, st_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pair_triple_event_counter #(
    .CNT_W(8), .HOLD(3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .en(en_a), .det(det_a),
    .clear(clr_a), .evt(evt_a),
    .cnt(cnt_a), .sat(sat_a),
    .state(st_a)
  );

  pair_triple_event_counter #(
    .CNT_W(2), .HOLD(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .en(en_b), .det(det_b),
    .clear(clr_b), .evt(evt_b),
    .cnt(cnt_b), .sat(sat_b),
    .state(st_b)
  );

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_a(
    input string      tag,
    input logic [1:0] st,
    input logic       ev,
    input logic [7:0] c,
    input logic       s
  );
    chk({tag, ".state"}, 8'(st_a), 8'(st));
    chk({tag, ".evt"}, 8'(evt_a), 8'(ev));
    chk({tag, ".cnt"}, cnt_a, c);
    chk({tag, ".sat"}, 8'(sat_a), 8'(s));
  endtask

  task automatic chk_b(
    input string      tag,
    input logic [1:0] st,
    input logic       ev,
    input logic [1:0] c,
    input logic       s
  );
    chk({tag, ".state"}, 8'(st_b), 8'(st));
    chk({tag, ".evt"}, 8'(evt_b), 8'(ev));
    chk({tag, ".cnt"}, 8'(cnt_b), 8'(c));
    chk({tag, ".sat"}, 8'(sat_b), 8'(s));
  endtask

  initial begin
    #3;
    chk_a("rst_a", 2'd0, 1'b0, 8'd0, 1'b0);
    chk_b("rst_b", 2'd0, 1'b0, 2'd0, 1'b0);
    #14 rst_n = 1'b1;
    tick(1);

`ifdef PAIR_TRIPLE_EVENT_COUNTER_SYNC_EN
    det_b = 1'b1;
    tick(1);
    det_b = 1'b0;
    chk_b("sync_e1", 2'd0, 1'b0, 2'd0, 1'b0);
    tick(1);
    chk_b("sync_e2", 2'd0, 1'b0, 2'd0, 1'b0);
    tick(1);
    chk_b("sync_e3", 2'd2, 1'b1, 2'd1, 1'b0);
    tick(1);
    chk_b("sync_e4", 2'd0, 1'b0, 2'd1, 1'b0);
`else
    det_a = 1'b1;
    tick(1);
    chk_a("q_e1", 2'd1, 1'b0, 8'd0, 1'b0);
    tick(1);
    chk_a("q_e2", 2'd1, 1'b0, 8'd0, 1'b0);
    tick(1);
    chk_a("q_e3", 2'd2, 1'b1, 8'd1, 1'b0);
    det_a = 1'b0;
    tick(1);
    chk_a("q_e4", 2'd0, 1'b0, 8'd1, 1'b0);

    det_a = 1'b1;
    tick(2);
    chk_a("g_e2", 2'd1, 1'b0, 8'd1, 1'b0);
    det_a = 1'b0;
    tick(1);
    chk_a("g_e3", 2'd0, 1'b0, 8'd1, 1'b0);

    det_a = 1'b1;
    tick(3);
    chk_a("l_fire", 2'd2, 1'b1, 8'd2, 1'b0);
    tick(17);
    chk_a("l_wait", 2'd3, 1'b0, 8'd2, 1'b0);
    det_a = 1'b0;
    tick(1);
    chk_a("l_end", 2'd0, 1'b0, 8'd2, 1'b0);

    det_a = 1'b1;
    tick(2);
    en_a = 1'b0;
    tick(1);
    chk_a("en_drop", 2'd0, 1'b0, 8'd2, 1'b0);
    en_a  = 1'b1;
    det_a = 1'b0;
    tick(1);

    det_a = 1'b1;
    tick(2);
    clr_a = 1'b1;
    tick(1);
    chk_a("clr_inc", 2'd2, 1'b1, 8'd0, 1'b0);
    clr_a = 1'b0;
    det_a = 1'b0;
    tick(1);
    chk_a("clr_aft", 2'd0, 1'b0, 8'd0, 1'b0);

    for (int k = 1; k <= 5; k++) begin
      det_b = 1'b1;
      tick(1);
      chk_b($sformatf("sat_p%0d", k),
            2'd2, 1'b1,
            (k >= 3) ? 2'd3 : 2'(k),
            (k >= 3));
      det_b = 1'b0;
      tick(1);
      chk("sat_low.evt", 8'(evt_b), 8'd0);
    end
    clr_b = 1'b1;
    tick(1);
    chk_b("sat_clr", 2'd0, 1'b0, 2'd0, 1'b0);
    clr_b = 1'b0;

    for (int k = 0; k < 5; k++) begin
      det_a = 1'b1;
      tick(3);
      det_a = 1'b0;
      tick(1);
    end
    chk("pre_rst.cnt", cnt_a, 8'd5);
    det_a = 1'b1;
    tick(1);
    chk("pre_rst.st", 8'(st_a), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_a("rst_mid", 2'd0, 1'b0, 8'd0, 1'b0);
    #2 rst_n = 1'b1;
    tick(2);
    chk_a("rst_f2", 2'd1, 1'b0, 8'd0, 1'b0);
    tick(1);
    chk_a("rst_f3", 2'd2, 1'b1, 8'd1, 1'b0);
    det_a = 1'b0;
    tick(1);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
